// File: rtl/srl_tb_pkg.sv
// Shared types and default sizing for the SRL lock-step monitor and its stimulus generator.
package srl_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    localparam int DEF_N      = 8;
    localparam int DEF_WARMUP = 4;
    localparam int DEF_RUN    = 24;
    localparam int DEF_CNT_W  = 16;

    // Bit 0 of the SRL outputs comes from an undriven input lane.
    localparam logic [7:0] DEF_IGNORE_MASK = 8'h01;

    function automatic int cnt_width(input int warmup, input int run);
        int m;
        m = (warmup > run) ? warmup : run;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/srl_compare_monitor_if.sv
// Bus bundle between the stimulus side (master) and the compare monitor (slave).
interface srl_compare_monitor_if
    import srl_tb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic [N-1:0]     test;
    logic [N-1:0]     pat;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err_cycle;
    logic [N-1:0]     first_err_mask;

    modport master (
        output start, test, pat,
        input  busy, done, fail, err_count, first_err_cycle, first_err_mask
    );

    modport slave (
        input  start, test, pat,
        output busy, done, fail, err_count, first_err_cycle, first_err_mask
    );
endinterface

// File: rtl/srl_compare_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/srl_compare_monitor.sv
// Lock-step comparator for the RTL vs netlist SRL buses: warm-up skip, fixed check run,
// sticky fail, saturating error count and first-mismatch capture.
module srl_compare_monitor
    import srl_tb_pkg::*;
#(
    parameter int           N           = DEF_N,
    parameter int           WARMUP      = DEF_WARMUP,
    parameter int           RUN         = DEF_RUN,
    parameter int           CNT_W       = DEF_CNT_W,
    parameter logic [N-1:0] IGNORE_MASK = N'(DEF_IGNORE_MASK)
) (
    input logic                  clk,
    input logic                  rst_n,
    srl_compare_monitor_if.slave bus
);
    localparam int CW = cnt_width(WARMUP, RUN);

    mon_state_e       r_state;
    mon_state_e       w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic [CNT_W-1:0] r_firstCycle;
    logic [N-1:0]     r_firstMask;
    logic [N-1:0]     w_diff;
    logic             w_mismatch;
    logic             w_restart;
    logic             w_lastWarm;
    logic             w_lastCheck;
    logic             w_inc;

    // Case inequality so an X/Z on an unmasked lane is flagged rather than silently passing.
    always_comb begin
        w_diff = '0;
        for (int i = 0; i < N; i++) begin
            w_diff[i] = (bus.test[i] !== bus.pat[i]) && !IGNORE_MASK[i];
        end
    end

    assign w_mismatch  = |w_diff;
    assign w_restart   = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastWarm  = (r_cnt == CW'(WARMUP - 1));
    assign w_lastCheck = (r_cnt == CW'(RUN - 1));
    assign w_inc       = (r_state == CHECK) && w_mismatch;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_restart) w_next = (WARMUP == 0) ? CHECK : WARM;
            WARM:       if (w_lastWarm) w_next = CHECK;
            CHECK:      if (w_lastCheck) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_firstCycle <= '0;
            r_firstMask  <= '0;
        end else begin
            r_busy <= (w_next == WARM) || (w_next == CHECK);
            r_done <= (w_next == DONE);
            if (w_restart) begin
                r_cnt        <= '0;
                r_fail       <= 1'b0;
                r_firstCycle <= '0;
                r_firstMask  <= '0;
            end else if (r_state == WARM) begin
                r_cnt <= w_lastWarm ? '0 : r_cnt + CW'(1);
            end else if (r_state == CHECK) begin
                r_cnt <= w_lastCheck ? '0 : r_cnt + CW'(1);
                if (w_mismatch && !r_fail) begin
                    r_fail       <= 1'b1;
                    r_firstCycle <= CNT_W'(r_cnt);
                    r_firstMask  <= w_diff;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_errCount (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc),
        .clr   (w_restart),
        .q     (bus.err_count)
    );

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.fail            = r_fail;
    assign bus.first_err_cycle = r_firstCycle;
    assign bus.first_err_mask  = r_firstMask;
endmodule

// File: tb/tb_srl_compare_monitor.sv
// Scoreboard bench: each run's expected result is queued when its stimulus is built and
// compared when the monitor raises done.
module tb_srl_compare_monitor;
    import srl_tb_pkg::*;

    localparam int W = 4;
    localparam int R = 24;
    localparam int T = W + R;
    localparam logic [7:0] IGN = 8'h01;

    typedef struct packed {
        logic        fail;
        logic [15:0] cnt;
        logic [15:0] cyc;
        logic [7:0]  mask;
    } exp_t;

    logic       clock;
    logic       resetN;
    logic       startA;
    logic       startB;
    logic [7:0] testD;
    logic [7:0] patD;

    logic [7:0] testVec [T];
    logic [7:0] patVec  [T];
    exp_t       expQ [$];

    int nVectors;
    int nMiscompares;
    logic        obsBusyEarly;
    logic        obsDoneEarly;
    logic [15:0] obsCntAfterStart;

    srl_compare_monitor_if #(.N(8), .CNT_W(16)) ifA ();
    srl_compare_monitor_if #(.N(8), .CNT_W(2))  ifB ();

    assign ifA.start = startA;
    assign ifA.test  = testD;
    assign ifA.pat   = patD;
    assign ifB.start = startB;
    assign ifB.test  = testD;
    assign ifB.pat   = patD;

    srl_compare_monitor #(.N(8), .WARMUP(W), .RUN(R), .CNT_W(16), .IGNORE_MASK(IGN)) dutA (
        .clk   (clock),
        .rst_n (resetN),
        .bus   (ifA)
    );

    srl_compare_monitor #(.N(8), .WARMUP(W), .RUN(R), .CNT_W(2), .IGNORE_MASK(IGN)) dutB (
        .clk   (clock),
        .rst_n (resetN),
        .bus   (ifB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent reference: walks the check window of the stimulus tables.
    function automatic exp_t modelRun(input int cntMax);
        exp_t e;
        logic [7:0] d;
        e = '0;
        for (int c = 0; c < R; c++) begin
            d = (testVec[W + c] ^ patVec[W + c]) & ~IGN;
            if (d != 8'h00) begin
                if (int'(e.cnt) < cntMax) e.cnt = e.cnt + 16'd1;
                if (!e.fail) begin
                    e.fail = 1'b1;
                    e.cyc  = 16'(c);
                    e.mask = d;
                end
            end
        end
        return e;
    endfunction

    task automatic fillSame();
        for (int i = 0; i < T; i++) begin
            testVec[i] = 8'($urandom);
            patVec[i]  = testVec[i];
        end
    endtask

    // Start pulse, then one table entry per clock; extraStartAt injects a start mid-run.
    task automatic applyStimulus(input bit sel, input int extraStartAt);
        @(negedge clock);
        if (sel) startB = 1'b1; else startA = 1'b1;
        testD = 8'($urandom);
        patD  = 8'($urandom);
        for (int i = 0; i < T; i++) begin
            @(negedge clock);
            if (i == 0) begin
                obsBusyEarly     = sel ? ifB.busy : ifA.busy;
                obsCntAfterStart = sel ? 16'(ifB.err_count) : ifA.err_count;
            end
            if (i == T - 1) obsDoneEarly = sel ? ifB.done : ifA.done;
            startA = (!sel && (i == extraStartAt));
            startB = ( sel && (i == extraStartAt));
            testD  = testVec[i];
            patD   = patVec[i];
        end
        @(negedge clock);
        startA = 1'b0;
        startB = 1'b0;
        testD  = 8'h00;
        patD   = 8'h00;
    endtask

    task automatic waitDone(input bit sel, output int waited);
        waited = 0;
        while (((sel ? ifB.done : ifA.done) !== 1'b1) && (waited < 8)) begin
            @(negedge clock);
            waited++;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        nVectors++; if (ifA.busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %0b expected 0", ifA.busy); end
        nVectors++; if (ifA.done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_done: got %0b expected 0", ifA.done); end
        nVectors++; if (ifA.fail !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_fail: got %0b expected 0", ifA.fail); end
        nVectors++; if (ifA.err_count !== 16'd0) begin nMiscompares++; $display("[TB] FAIL reset_count: got %0h expected 0", ifA.err_count); end
        nVectors++; if (ifA.first_err_mask !== 8'h00) begin nMiscompares++; $display("[TB] FAIL reset_mask: got %0h expected 0", ifA.first_err_mask); end
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_clean();
        int waited;
        exp_t e;
        fillSame();
        expQ.push_back(modelRun(65535));
        applyStimulus(1'b0, -1);
        waitDone(1'b0, waited);
        e = expQ.pop_front();
        nVectors++; if (obsBusyEarly !== 1'b1) begin nMiscompares++; $display("[TB] FAIL clean_busy_after_start: got %0b expected 1", obsBusyEarly); end
        nVectors++; if (obsDoneEarly !== 1'b0) begin nMiscompares++; $display("[TB] FAIL clean_done_early: got %0b expected 0", obsDoneEarly); end
        nVectors++; if (waited != 0) begin nMiscompares++; $display("[TB] FAIL clean_done_latency: got %0d extra cycles expected 0", waited); end
        nVectors++; if (ifA.busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL clean_busy_at_done: got %0b expected 0", ifA.busy); end
        nVectors++; if (ifA.fail !== e.fail) begin nMiscompares++; $display("[TB] FAIL clean_fail: got %0b expected %0b", ifA.fail, e.fail); end
        nVectors++; if (ifA.err_count !== e.cnt) begin nMiscompares++; $display("[TB] FAIL clean_count: got %0h expected %0h", ifA.err_count, e.cnt); end
        repeat (2) @(negedge clock);
        nVectors++; if (ifA.done !== 1'b1) begin nMiscompares++; $display("[TB] FAIL clean_done_held: got %0b expected 1", ifA.done); end
    endtask

    task automatic test_errors(input string name, input int extraStartAt);
        int waited;
        exp_t e;
        expQ.push_back(modelRun(65535));
        applyStimulus(1'b0, extraStartAt);
        waitDone(1'b0, waited);
        e = expQ.pop_front();
        nVectors++; if (waited != 0) begin nMiscompares++; $display("[TB] FAIL %s_done_latency: got %0d extra cycles expected 0", name, waited); end
        nVectors++; if (ifA.fail !== e.fail) begin nMiscompares++; $display("[TB] FAIL %s_fail: got %0b expected %0b", name, ifA.fail, e.fail); end
        nVectors++; if (ifA.err_count !== e.cnt) begin nMiscompares++; $display("[TB] FAIL %s_count: got %0h expected %0h", name, ifA.err_count, e.cnt); end
        nVectors++; if (ifA.first_err_cycle !== e.cyc) begin nMiscompares++; $display("[TB] FAIL %s_cycle: got %0h expected %0h", name, ifA.first_err_cycle, e.cyc); end
        nVectors++; if (ifA.first_err_mask !== e.mask) begin nMiscompares++; $display("[TB] FAIL %s_mask: got %0h expected %0h", name, ifA.first_err_mask, e.mask); end
    endtask

    task automatic test_single_error();
        fillSame();
        patVec[W + 5] = patVec[W + 5] ^ 8'h08;
        test_errors("single", -1);
    endtask

    task automatic test_two_errors();
        fillSame();
        patVec[W + 2] = patVec[W + 2] ^ 8'h06;
        patVec[W + 9] = patVec[W + 9] ^ 8'h80;
        test_errors("two", -1);
    endtask

    task automatic test_ignored_bits();
        fillSame();
        for (int i = 0; i < T; i++) patVec[i] = patVec[i] ^ 8'h01;
        patVec[1] = patVec[1] ^ 8'h10;
        test_errors("ignored", -1);
    endtask

    task automatic test_start_while_busy();
        fillSame();
        patVec[W + 1]  = patVec[W + 1]  ^ 8'h40;
        patVec[W + 20] = patVec[W + 20] ^ 8'h04;
        test_errors("busy_start", W + 12);
    endtask

    task automatic test_back_to_back();
        fillSame();
        patVec[W]         = patVec[W]         ^ 8'h10;
        patVec[W + R - 1] = patVec[W + R - 1] ^ 8'h80;
        test_errors("b2b", -1);
        nVectors++; if (obsCntAfterStart !== 16'd0) begin nMiscompares++; $display("[TB] FAIL b2b_cleared_on_start: got %0h expected 0", obsCntAfterStart); end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        exp_t e;
        fillSame();
        patVec[W + 3] = patVec[W + 3] ^ 8'h20;
        @(negedge clock);
        startA = 1'b1;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clock);
            startA = 1'b0;
            testD  = testVec[i];
            patD   = patVec[i];
        end
        @(negedge clock);
        nVectors++; if (ifA.fail !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rst_pre_fail: got %0b expected 1", ifA.fail); end
        resetN = 1'b0;
        #1;
        nVectors++; if (ifA.busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_busy: got %0b expected 0", ifA.busy); end
        nVectors++; if (ifA.fail !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_fail: got %0b expected 0", ifA.fail); end
        nVectors++; if (ifA.err_count !== 16'd0) begin nMiscompares++; $display("[TB] FAIL rst_count: got %0h expected 0", ifA.err_count); end
        nVectors++; if (ifA.first_err_cycle !== 16'd0) begin nMiscompares++; $display("[TB] FAIL rst_cycle: got %0h expected 0", ifA.first_err_cycle); end
        nVectors++; if (ifA.first_err_mask !== 8'h00) begin nMiscompares++; $display("[TB] FAIL rst_mask: got %0h expected 0", ifA.first_err_mask); end
        @(negedge clock);
        resetN = 1'b1;
        fillSame();
        expQ.push_back(modelRun(65535));
        applyStimulus(1'b0, -1);
        waitDone(1'b0, waited);
        e = expQ.pop_front();
        nVectors++; if (waited != 0) begin nMiscompares++; $display("[TB] FAIL rst_rerun_latency: got %0d extra cycles expected 0", waited); end
        nVectors++; if (ifA.fail !== e.fail) begin nMiscompares++; $display("[TB] FAIL rst_rerun_fail: got %0b expected %0b", ifA.fail, e.fail); end
    endtask

    task automatic test_saturate();
        int waited;
        exp_t e;
        fillSame();
        for (int i = 0; i < T; i++) patVec[i] = testVec[i] ^ 8'h02;
        expQ.push_back(modelRun(3));
        applyStimulus(1'b1, -1);
        waitDone(1'b1, waited);
        e = expQ.pop_front();
        nVectors++; if (waited != 0) begin nMiscompares++; $display("[TB] FAIL sat_done_latency: got %0d extra cycles expected 0", waited); end
        nVectors++; if (ifB.err_count !== e.cnt[1:0]) begin nMiscompares++; $display("[TB] FAIL sat_count: got %0h expected %0h", ifB.err_count, e.cnt[1:0]); end
        nVectors++; if (ifB.fail !== e.fail) begin nMiscompares++; $display("[TB] FAIL sat_fail: got %0b expected %0b", ifB.fail, e.fail); end
        nVectors++; if (ifB.first_err_mask !== e.mask) begin nMiscompares++; $display("[TB] FAIL sat_mask: got %0h expected %0h", ifB.first_err_mask, e.mask); end
        nVectors++; if (ifB.first_err_cycle !== e.cyc[1:0]) begin nMiscompares++; $display("[TB] FAIL sat_cycle: got %0h expected %0h", ifB.first_err_cycle, e.cyc[1:0]); end
        startB = 1'b1;
        @(negedge clock);
        startB = 1'b0;
        nVectors++; if (ifB.err_count !== 2'd0) begin nMiscompares++; $display("[TB] FAIL sat_restart_count: got %0h expected 0", ifB.err_count); end
        nVectors++; if (ifB.busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL sat_restart_busy: got %0b expected 1", ifB.busy); end
        nVectors++; if (ifB.done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL sat_restart_done: got %0b expected 0", ifB.done); end
        nVectors++; if (ifB.fail !== 1'b0) begin nMiscompares++; $display("[TB] FAIL sat_restart_fail: got %0b expected 0", ifB.fail); end
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        resetN       = 1'b0;
        startA       = 1'b0;
        startB       = 1'b0;
        testD        = 8'h00;
        patD         = 8'h00;
        test_reset();
        test_clean();
        test_single_error();
        test_two_errors();
        test_ignored_bits();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
